// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: WORDS x 32-bit add/subtract computed one word per cycle through a single 32-bit slice.
// Optional feature: define MPADD_OVF_EN to add the registered signed-overflow output.
module mp_addsub_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sub_flag,
    input  logic [32*WORDS-1:0] src1,
    input  logic [32*WORDS-1:0] src2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WORDS-1:0] result,
    output logic                carry_out
`ifdef MPADD_OVF_EN
    ,
    output logic                overflow
`endif
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [WORDS-1:0][31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic sub_q, sub_d, carry_q, carry_d, co_q, co_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] a_w, b_w;
    logic [32:0] sum;
    logic last;
`ifdef MPADD_OVF_EN
    logic ovf_q, ovf_d;
    assign overflow = ovf_q;
`endif
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = res_q;
    assign carry_out = co_q;
    // one 32-bit slice per CALC cycle, carry chained through carry_q; subtraction is a + ~b + 1
    always_comb begin
        a_w = a_q[cnt_q];
        b_w = b_q[cnt_q] ^ {32{sub_q}};
        sum = {1'b0, a_w} + {1'b0, b_w} + {32'd0, carry_q};
        last = cnt_q == CW'(WORDS - 1);
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        res_d = res_q;
        sub_d = sub_q;
        carry_d = carry_q;
        co_d = co_q;
        cnt_d = cnt_q;
`ifdef MPADD_OVF_EN
        ovf_d = ovf_q;
`endif
        if (state_q == IDLE && in_valid) begin
            state_d = CALC;
            a_d = src1;
            b_d = src2;
            sub_d = sub_flag;
            carry_d = sub_flag;
            cnt_d = '0;
        end else if (state_q == CALC) begin
            res_d[cnt_q] = sum[31:0];
            carry_d = sum[32];
            cnt_d = last ? cnt_q : cnt_q + CW'(1);
            if (last) begin
                state_d = DONE;
                co_d = sum[32];
`ifdef MPADD_OVF_EN
                ovf_d = (a_w[31] == b_w[31]) && (sum[31] != a_w[31]);
`endif
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    // state and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            sub_q <= 1'b0;
            carry_q <= 1'b0;
            co_q <= 1'b0;
            cnt_q <= '0;
`ifdef MPADD_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            sub_q <= sub_d;
            carry_q <= carry_d;
            co_q <= co_d;
            cnt_q <= cnt_d;
`ifdef MPADD_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end
endmodule

// File: doc/mp_addsub_seq.md
# mp_addsub_seq

Multi-precision add/subtract sequencer that runs a single 32-bit ripple-carry slice over several cycles to produce a WORDS×32-bit sum or difference. Operands are captured through a valid/ready handshake and processed one 32-bit word per cycle, least-significant word first, with the carry held in a register between words. The result is presented through a second valid/ready handshake. The block is the wide-operand controller placed in front of the 32-bit adder datapath, so the design never needs a full-width combinational adder.

## Interface
- WORDS, 4, number of 32-bit words per operand; must be at least 1. Total width W = 32*WORDS.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge.
- sub_flag  in  1  0 = src1+src2, 1 = src1−src2; sampled with operands.
- src1  in  W  first operand.
- src2  in  W  second operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result on out_valid && out_ready.
- result  out  W  sum or difference, modulo 2^W.
- carry_out  out  1  carry out of bit W−1; for subtraction, 1 = no borrow.
- overflow  out  1  signed overflow; exists only when MPADD_OVF_EN is defined.

## Operation
- FSM states and transitions:
  - IDLE → CALC on input handshake.
  - CALC → DONE after word WORDS−1 is computed.
  - DONE → IDLE on output handshake.
- in_ready = (state == IDLE), decoded combinationally. in_valid is ignored outside IDLE.
- Accept actions:
  - Register src1, src2 and sub_flag; inputs may change freely afterwards.
  - Word counter ← 0.
  - Carry register ← sub_flag.
- Each CALC cycle, for word i = counter:
  - b = src2_reg[i] XOR {32{sub_reg}}.
  - {c, s} = src1_reg[i] + b + carry.
  - result[i] ← s; carry ← c; counter ← counter + 1.
- On the last word, carry_out ← final carry.
- Counter width is max(1, $clog2(WORDS)). Counter compare is against WORDS−1, so there is no counter wrap.
- DONE:
  - out_valid = 1.
  - result, carry_out and overflow are held stable until the output handshake.
- Reset values (any state): state IDLE, counter 0, carry 0, result 0, carry_out 0, overflow 0, out_valid 0, in_ready 1.
- Reset mid-operation aborts the operation, and no result is produced. The first request after reset release is handled normally.

## Timing
- Input handshake at edge E0. Words 0..WORDS−1 are computed at edges E1..E_WORDS.
- out_valid rises after E_WORDS, i.e. latency from accept = WORDS cycles.
- Output handshake at edge Eh: out_valid falls and in_ready rises after Eh.
- No bypass from DONE directly to CALC. Best-case throughput is one operation per WORDS+2 cycles.
- out_ready held low keeps DONE indefinitely.
- Partial result words are visible on result during CALC. They are valid only when out_valid = 1.
- WORDS = 1: single CALC cycle, latency 1.

## Configuration
- MPADD_OVF_EN defined:
  - The overflow port exists.
  - On the last word, overflow ← (a_msb == b_msb) && (s_msb != a_msb), where b is the inverted src2 word for subtraction.
  - overflow is registered, resets to 0 and holds through DONE.
- MPADD_OVF_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Cross-word carry, add: WORDS=4, src1=128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, src2=1 → result=128'h0000_0000_0000_0001_0000_0000_0000_0000, carry_out=0, out_valid exactly 4 cycles after accept.
- Subtract:
  - 0−1 → result all ones, carry_out=0.
  - 5−3 → result 2, carry_out=1.
- Full wrap: all-ones + 1 → result 0, carry_out=1, overflow=0. With MPADD_OVF_EN, 128'h7FFF…F + 1 → overflow=1, result 128'h8000…0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and operands → result and out_valid stable, in_ready=0, no new request accepted.
- Reset: assert rst_n=0 in the 2nd CALC cycle → all outputs take reset values immediately. Next request 10+20 → result 30.
- Random: 200 operations with random operands and sub_flag, random in_valid/out_ready gaps → every result and carry_out match a W-bit reference model.
